cv32e40x_b_clmul: RTL

Iterative carry-less multiply unit for the Zbc subset of RV32B: `clmul`, `clmulh` and `clmulr`. It sits in EX, downstream of the B decoder. The ALU hands it operands whenever the decoded operator is a carry-less multiply, stalls on the handshake and returns the 32-bit result to the writeback path. It processes `BITS_PER_CYCLE` multiplier bits per cycle, trading area for latency.

---
 rtl/cv32e40x_pkg.sv | 40 ++++
 rtl/cv32e40x_b_clmul_step.sv | 36 +++
 rtl/cv32e40x_b_clmul.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the Zbc carry-less multiply unit.
// Provides the unit operator, FSM state encoding and the mapping from the
// ALU operator space onto the unit operator.
package cv32e40x_pkg;

  // Carry-less multiply result selection
  typedef enum logic [1:0] {
    CLMUL_LO  = 2'd0,
    CLMUL_HI  = 2'd1,
    CLMUL_REV = 2'd2
  } clmul_op_e;

  // Carry-less multiply control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } clmul_state_e;

  // Subset of ALU operators relevant to the carry-less multiply path
  typedef enum logic [5:0] {
    ALU_ADD       = 6'd0,
    ALU_B_CLMUL   = 6'd48,
    ALU_B_CLMULH  = 6'd49,
    ALU_B_CLMULR  = 6'd50
  } alu_op_e;

  // Map the decoded ALU operator onto the unit operator
  function automatic clmul_op_e alu_to_clmul_op(alu_op_e alu_op);
    clmul_op_e op;
    op = CLMUL_LO;
    case (alu_op)
      ALU_B_CLMULH: op = CLMUL_HI;
      ALU_B_CLMULR: op = CLMUL_REV;
      default:      op = CLMUL_LO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cv32e40x_b_clmul_step.sv
// One iteration of the carry-less multiply: folds BITS_PER_CYCLE shifted
// copies of the multiplicand into the accumulator.
// Ports: acc (current accumulator), a64 (zero-extended multiplicand),
//        b_slice (multiplier bits for this step), cnt (step index),
//        acc_nxt_c (updated accumulator, combinational).
module cv32e40x_b_clmul_step #(
  parameter int unsigned BITS_PER_CYCLE = 4,
  parameter int unsigned CNT_W          = 3
) (
  input  logic [63:0]               acc,
  input  logic [63:0]               a64,
  input  logic [BITS_PER_CYCLE-1:0] b_slice,
  input  logic [CNT_W-1:0]          cnt,
  output logic [63:0]               acc_nxt_c
);

  localparam int unsigned SH_W = 6;

  logic [SH_W-1:0] base_c;

  // Bit position of b_slice[0] within the multiplier
  always_comb begin
    base_c = SH_W'(cnt) * SH_W'(BITS_PER_CYCLE);
  end

  // XOR tree of the selected partial products
  always_comb begin
    acc_nxt_c = acc;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_slice[j]) begin
        acc_nxt_c = acc_nxt_c ^ (a64 << (base_c + SH_W'(j)));
      end
    end
  end

endmodule

// File: rtl/cv32e40x_b_clmul.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) for the EX stage.
// Consumes BITS_PER_CYCLE multiplier bits per cycle; latency is constant.
// Ports: clk/rst (sync active-high), kill_i (flush), valid_i/ready_o
//        (operand handshake), op_i/op_a_i/op_b_i (operator and operands),
//        valid_o/ready_i (result handshake), result_o (registered result).
module cv32e40x_b_clmul
  import cv32e40x_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  clmul_op_e   op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  localparam int unsigned NSTEPS = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(NSTEPS);
  localparam int unsigned SH_W   = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

  // Elaboration-time legality check of the step width
  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
    $error("cv32e40x_b_clmul: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  clmul_state_e state_q, state_d;
  logic         accept_c;
  logic         finish_c;

  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  clmul_op_e        op_q;
  logic [63:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      result_q;

  logic [63:0]               a64_c;
  logic [63:0]               acc_nxt_c;
  logic [SH_W-1:0]           base_c;
  logic [31:0]               b_shift_c;
  logic [BITS_PER_CYCLE-1:0] b_slice_c;
  logic [31:0]               sel_c;

  // Next-state logic; kill always returns to IDLE and blocks acceptance
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !kill_i) begin
          state_d  = BUSY;
          accept_c = 1'b1;
        end
      end
      BUSY: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          finish_c = 1'b1;
        end
      end
      DONE: begin
        if (ready_i || kill_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier slice for the current step
  always_comb begin
    a64_c     = {32'h0, op_a_q};
    base_c    = SH_W'(cnt_q) * SH_W'(BITS_PER_CYCLE);
    b_shift_c = op_b_q >> base_c;
    b_slice_c = b_shift_c[BITS_PER_CYCLE-1:0];
  end

  cv32e40x_b_clmul_step #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (CNT_W)
  ) u_step (
    .acc       (acc_q),
    .a64       (a64_c),
    .b_slice   (b_slice_c),
    .cnt       (cnt_q),
    .acc_nxt_c (acc_nxt_c)
  );

  // Result select from the completed product (taken from the final step)
  always_comb begin
    sel_c = acc_nxt_c[31:0];
    case (op_q)
      CLMUL_HI:  sel_c = acc_nxt_c[63:32];
      CLMUL_REV: sel_c = acc_nxt_c[62:31];
      default:   sel_c = acc_nxt_c[31:0];
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_q     <= CLMUL_LO;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        op_a_q <= op_a_i;
        op_b_q <= op_b_i;
        op_q   <= op_i;
        acc_q  <= '0;
        cnt_q  <= '0;
      end else if (state_q == BUSY && !kill_i) begin
        acc_q <= acc_nxt_c;
        cnt_q <= cnt_q + CNT_W'(1);
        if (finish_c) begin
          result_q <= sel_c;
        end
      end
    end
  end

  assign ready_o  = (state_q == IDLE) && !rst;
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule
